// File: rtl/serial_arith_pkg.sv
// rtl/serial_arith_pkg.sv - shared types and helpers for the bit-serial arithmetic blocks
package serial_arith_pkg;

    // Sequencer states shared by the serial arithmetic units
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } serial_state_e;

    // Bit-counter width that can represent every value 0..width
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_subtractor.sv
// rtl/full_subtractor.sv - gate-level one-bit full subtractor cell
module full_subtractor (
    output logic d,
    output logic b_out,
    input  logic x,
    input  logic y,
    input  logic b_in
);

    logic x_n;
    logic xy_x;
    logic t_xn_y;
    logic t_xn_b;
    logic t_y_b;
    logic t_or0;

    // Difference bit is the three-way parity of the inputs
    xor g_x0 (xy_x, x, y);
    xor g_x1 (d, xy_x, b_in);

    // Borrow out whenever the subtrahend plus borrow exceeds the minuend bit
    not g_n0 (x_n, x);
    and g_a0 (t_xn_y, x_n, y);
    and g_a1 (t_xn_b, x_n, b_in);
    and g_a2 (t_y_b, y, b_in);
    or  g_o0 (t_or0, t_xn_y, t_xn_b);
    or  g_o1 (b_out, t_or0, t_y_b);

endmodule

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - LSB-first bit-serial unsigned subtractor with start/busy/done handshake
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             borrow_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    serial_state_e    state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] diff_sr;
    logic [WIDTH-1:0] diff_next;
    logic [CW-1:0]    cnt;
    logic             bq;
    logic             cell_d;
    logic             cell_bo;
    logic             last_bit;

    // The single datapath cell, fed from the shift-register LSBs and the borrow flop
    full_subtractor u_cell (
        .d     (cell_d),
        .b_out (cell_bo),
        .x     (a_sr[0]),
        .y     (b_sr[0]),
        .b_in  (bq)
    );

    // Accumulator after this cycle's bit enters at the MSB; written this way so WIDTH=1 needs no special slice
    always_comb begin
        diff_next            = diff_sr >> 1;
        diff_next[WIDTH-1]   = cell_d;
        last_bit             = (cnt == LAST_BIT);
    end

    // Sequencer, shift datapath and registered outputs; reset wins over start
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            a_sr       <= '0;
            b_sr       <= '0;
            diff_sr    <= '0;
            cnt        <= '0;
            bq         <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr    <= a;
                        b_sr    <= b;
                        bq      <= borrow_in;
                        cnt     <= '0;
                        diff_sr <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end else begin
                        state   <= IDLE;
                    end
                end
                SHIFT: begin
                    a_sr    <= a_sr >> 1;
                    b_sr    <= b_sr >> 1;
                    diff_sr <= diff_next;
                    bq      <= cell_bo;
                    cnt     <= cnt + CW'(1);
                    if (last_bit) begin
                        diff       <= diff_next;
                        borrow_out <= cell_bo;
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        state      <= DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_subtractor.sv
// tb/tb_serial_subtractor.sv - directed self-checking bench for serial_subtractor
module tb_serial_subtractor;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       borrow_in;
    logic       busy;
    logic       done;
    logic [7:0] diff;
    logic       borrow_out;

    int n_cmp;
    int n_bad;

    serial_subtractor #(.WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic launch(input logic [7:0] av, input logic [7:0] bv, input logic bi);
        a = av;
        b = bv;
        borrow_in = bi;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int busy_n);
        lat = 0;
        busy_n = 0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_n++;
            step();
            lat++;
        end
    endtask

    task automatic run_op(input string tag, input logic [7:0] av, input logic [7:0] bv,
                          input logic bi, input logic [7:0] exp_d, input logic exp_bo);
        int lat;
        int bn;
        launch(av, bv, bi);
        wait_done(lat, bn);
        chk({tag, ".latency"}, lat, 8);
        chk({tag, ".busy_cycles"}, bn, 8);
        chk({tag, ".busy_at_done"}, {31'd0, busy}, 0);
        chk({tag, ".diff"}, {24'd0, diff}, {24'd0, exp_d});
        chk({tag, ".borrow_out"}, {31'd0, borrow_out}, {31'd0, exp_bo});
        step();
        chk({tag, ".done_pulse_end"}, {31'd0, done}, 0);
        chk({tag, ".diff_held"}, {24'd0, diff}, {24'd0, exp_d});
    endtask

    initial begin
        int lat;
        int bn;
        int saw_done;
        logic [8:0] ref9;
        logic [7:0] ra;
        logic [7:0] rb;
        logic       rbi;
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        start = 1'b1;
        a = 8'hAA;
        b = 8'h11;
        borrow_in = 1'b1;
        step();
        step();
        chk("reset.busy", {31'd0, busy}, 0);
        chk("reset.done", {31'd0, done}, 0);
        chk("reset.diff", {24'd0, diff}, 0);
        chk("reset.borrow_out", {31'd0, borrow_out}, 0);
        start = 1'b0;
        rst = 1'b0;
        step();

        run_op("op_5a_23", 8'h5A, 8'h23, 1'b0, 8'h37, 1'b0);
        run_op("op_00_01", 8'h00, 8'h01, 1'b0, 8'hFF, 1'b1);
        run_op("op_80_7f_b1", 8'h80, 8'h7F, 1'b1, 8'h00, 1'b0);
        run_op("op_10_10_b1", 8'h10, 8'h10, 1'b1, 8'hFF, 1'b1);

        // start mid-SHIFT is ignored
        launch(8'h5A, 8'h23, 1'b0);
        step();
        step();
        a = 8'hFF;
        b = 8'h01;
        borrow_in = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(lat, bn);
        chk("ignore.latency", lat + 3, 8);
        chk("ignore.diff", {24'd0, diff}, 32'h37);
        chk("ignore.borrow_out", {31'd0, borrow_out}, 0);

        // start during the done cycle is accepted
        a = 8'h10;
        b = 8'h01;
        borrow_in = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("b2b.busy", {31'd0, busy}, 1);
        wait_done(lat, bn);
        chk("b2b.spacing", lat + 1, 9);
        chk("b2b.diff", {24'd0, diff}, 32'h0F);
        chk("b2b.borrow_out", {31'd0, borrow_out}, 0);
        step();

        // reset in the 4th SHIFT cycle aborts
        launch(8'h5A, 8'h23, 1'b0);
        step();
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort.busy", {31'd0, busy}, 0);
        chk("abort.done", {31'd0, done}, 0);
        chk("abort.diff", {24'd0, diff}, 0);
        chk("abort.borrow_out", {31'd0, borrow_out}, 0);
        saw_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (done === 1'b1) saw_done = 1;
            step();
        end
        chk("abort.no_done", saw_done, 0);
        run_op("op_c3_3c", 8'hC3, 8'h3C, 1'b0, 8'h87, 1'b0);

        // random sweep against a 9-bit reference
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rbi = 1'($urandom_range(0, 1));
            ref9 = {1'b0, ra} - {1'b0, rb} - {8'd0, rbi};
            launch(ra, rb, rbi);
            wait_done(lat, bn);
            chk("rand.latency", lat, 8);
            chk("rand.diff", {24'd0, diff}, {24'd0, ref9[7:0]});
            chk("rand.borrow_out", {31'd0, borrow_out}, {31'd0, ref9[8]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
